// File: rtl/bw_con_fold_pkg.sv
// rtl/bw_con_fold_pkg.sv - shared types, constants and helpers for the constant-prefix folding stage
package bw_con_fold_pkg;

  localparam int WID     = 40;
  localparam int VAL_W   = 80;
  localparam int IMM15_W = 15;
  localparam int PAY_W   = 27;
  localparam int C3_W    = VAL_W - 69;

  // Bit offsets of each prefix payload inside the assembled immediate.
  localparam int OFS_C1 = 15;
  localparam int OFS_C2 = 42;
  localparam int OFS_C3 = 69;

  localparam logic [5:0] OP_CON1 = 6'd61;
  localparam logic [5:0] OP_CON2 = 6'd62;
  localparam logic [5:0] OP_CON3 = 6'd63;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } fold_state_t;

  typedef struct packed {
    logic [WID-1:0]   pc;
    logic [WID-1:0]   ins;
    logic [VAL_W-1:0] imm;
    logic [2:0]       len;
    logic             perr;
  } con_fold_t;

  // CON1..CON3 occupy the three highest opcode values.
  function automatic logic is_con(input logic [5:0] opcode);
    return opcode >= OP_CON1;
  endfunction

endpackage

// File: rtl/bw_con_immgen.sv
// rtl/bw_con_immgen.sv - assembles the 80-bit extended immediate from prefix payloads and imm15
module bw_con_immgen
  import bw_con_fold_pkg::*;
(
  input  logic               p1,
  input  logic               p2,
  input  logic               p3,
  input  logic [PAY_W-1:0]   c1,
  input  logic [PAY_W-1:0]   c2,
  input  logic [PAY_W-1:0]   c3,
  input  logic [IMM15_W-1:0] imm15,
  output logic [VAL_W-1:0]   imm
);

  logic [PAY_W-1:0] c1_m;
  logic [PAY_W-1:0] c2_m;

  // Only the low bits of CON3 fit above bit 69; the rest of its payload is dropped.
  logic unused_c3;
  assign unused_c3 = ^c3[PAY_W-1:C3_W];

  // Highest present prefix decides the sign position; absent lower fields read as zero.
  always_comb begin
    c1_m = p1 ? c1 : '0;
    c2_m = p2 ? c2 : '0;
    imm  = '0;
    if (p3) begin
      imm = {c3[C3_W-1:0], c2_m, c1_m, imm15};
    end else if (p2) begin
      imm = {{(VAL_W-OFS_C3){c2[PAY_W-1]}}, c2, c1_m, imm15};
    end else if (p1) begin
      imm = {{(VAL_W-OFS_C2){c1[PAY_W-1]}}, c1, imm15};
    end else begin
      imm = {{(VAL_W-OFS_C1){imm15[IMM15_W-1]}}, imm15};
    end
  end

endmodule

// File: rtl/bw_con_fold.sv
// rtl/bw_con_fold.sv - folds CON1/CON2/CON3 prefix words into the following instruction's immediate
module bw_con_fold
  import bw_con_fold_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WID-1:0]   in_pc_i,
  input  logic [WID-1:0]   in_ins_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WID-1:0]   out_pc_o,
  output logic [WID-1:0]   out_ins_o,
  output logic [VAL_W-1:0] out_imm_o,
  output logic [2:0]       out_len_o,
  output logic             out_perr_o
);

  fold_state_t      state_q, state_d;
  logic [PAY_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic             p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [WID-1:0]   first_pc_q, first_pc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             perr_q, perr_d;
  con_fold_t        out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [5:0]       opcode;
  logic [1:0]       lvl;
  logic             prefix;
  logic             accept;
  logic             dup;
  logic             misorder;
  logic [VAL_W-1:0] imm;

  assign opcode = in_ins_i[38:33];
  assign lvl    = opcode[1:0];
  assign prefix = is_con(opcode);

  // Prefixes obey the same back-pressure as real instructions so the group order never splits.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  assign dup      = (lvl == 2'd1 && p1_q) || (lvl == 2'd2 && p2_q) || (lvl == 2'd3 && p3_q);
  assign misorder = (lvl == 2'd1 && (p2_q || p3_q)) || (lvl == 2'd2 && p3_q);

  bw_con_immgen u_immgen (
    .p1    (p1_q),
    .p2    (p2_q),
    .p3    (p3_q),
    .c1    (c1_q),
    .c2    (c2_q),
    .c3    (c3_q),
    .imm15 (in_ins_i[32:18]),
    .imm   (imm)
  );

  // Prefix accumulation, output register load and handshake; flush overrides all of it.
  always_comb begin
    state_d     = state_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    c3_d        = c3_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    first_pc_d  = first_pc_q;
    cnt_d       = cnt_q;
    perr_d      = perr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (flush_i) begin
      state_d     = ST_IDLE;
      p1_d        = 1'b0;
      p2_d        = 1'b0;
      p3_d        = 1'b0;
      cnt_d       = 2'd0;
      perr_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (prefix) begin
          state_d = ST_ACC;
          if (state_q == ST_IDLE) begin
            first_pc_d = in_pc_i;
            cnt_d      = 2'd1;
            perr_d     = 1'b0;
          end else begin
            perr_d = perr_q || dup || misorder || (cnt_q == 2'd3);
            cnt_d  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
          end
          case (lvl)
            2'd1: begin c1_d = in_ins_i[32:6]; p1_d = 1'b1; end
            2'd2: begin c2_d = in_ins_i[32:6]; p2_d = 1'b1; end
            default: begin c3_d = in_ins_i[32:6]; p3_d = 1'b1; end
          endcase
        end else begin
          out_d.pc    = (state_q == ST_ACC) ? first_pc_q : in_pc_i;
          out_d.ins   = in_ins_i;
          out_d.imm   = imm;
          out_d.len   = {1'b0, cnt_q} + 3'd1;
          out_d.perr  = perr_q;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
          p1_d        = 1'b0;
          p2_d        = 1'b0;
          p3_d        = 1'b0;
          cnt_d       = 2'd0;
          perr_d      = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset discards any partial group.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      c1_q        <= '0;
      c2_q        <= '0;
      c3_q        <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      p3_q        <= 1'b0;
      first_pc_q  <= '0;
      cnt_q       <= 2'd0;
      perr_q      <= 1'b0;
      out_q       <= '{pc: '0, ins: '0, imm: '0, len: 3'd1, perr: 1'b0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      first_pc_q  <= first_pc_d;
      cnt_q       <= cnt_d;
      perr_q      <= perr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pc_o    = out_q.pc;
  assign out_ins_o   = out_q.ins;
  assign out_imm_o   = out_q.imm;
  assign out_len_o   = out_q.len;
  assign out_perr_o  = out_q.perr;

endmodule

// File: tb/tb_bw_con_fold.sv
// tb/tb_bw_con_fold.sv - scoreboard bench for the constant-prefix folding stage
module tb_bw_con_fold;
  import bw_con_fold_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [39:0] in_pc, in_ins, out_pc, out_ins;
  logic [79:0] out_imm;
  logic [2:0]  out_len;
  logic        out_perr;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] ADDI = 6'd4;
  localparam logic [5:0] ORI  = 6'd5;

  always #5 clk = ~clk;

  bw_con_fold dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pc_i(in_pc), .in_ins_i(in_ins),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_ins_o(out_ins), .out_imm_o(out_imm), .out_len_o(out_len), .out_perr_o(out_perr)
  );

  typedef struct {
    logic [39:0] pc;
    int          lvl;
    logic [26:0] pay;
  } pre_t;

  pre_t      pend[$];
  con_fold_t expq[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk_ri(input logic [5:0] op, input logic [14:0] i15);
    return {1'b0, op, i15, 18'h0};
  endfunction

  function automatic logic [39:0] mk_con(input int lvl, input logic [26:0] pay);
    logic [5:0] op;
    op = 6'(60 + lvl);
    return {1'b0, op, pay, 6'h0};
  endfunction

  // Reference: last payload per level, highest level sets sign position, order must strictly rise.
  function automatic con_fold_t build(input logic [39:0] pc, input logic [39:0] ins);
    con_fold_t   e;
    logic [79:0] v;
    logic [26:0] pay[4];
    bit          pres[4];
    int          maxl, w;
    bit          err;
    for (int i = 0; i < 4; i++) begin pres[i] = 0; pay[i] = '0; end
    maxl = 0;
    err  = 0;
    foreach (pend[i]) begin
      if (pend[i].lvl <= maxl) err = 1;
      else maxl = pend[i].lvl;
      pres[pend[i].lvl] = 1;
      pay[pend[i].lvl]  = pend[i].pay;
    end
    if (pend.size() > 3) err = 1;
    v = 80'(ins[32:18]);
    if (pres[1]) v = v | (80'(pay[1]) << 15);
    if (pres[2]) v = v | (80'(pay[2]) << 42);
    if (pres[3]) v = v | (80'(pay[3]) << 69);
    w = (maxl == 3) ? 80 : (maxl == 2) ? 69 : (maxl == 1) ? 42 : 15;
    if (w < 80 && v[w-1]) v = v | ~((80'd1 << w) - 80'd1);
    e.pc   = (pend.size() > 0) ? pend[0].pc : pc;
    e.ins  = ins;
    e.imm  = v;
    e.len  = 3'((pend.size() > 3) ? 4 : pend.size() + 1);
    e.perr = err;
    return e;
  endfunction

  // Model: follows accepted words and queues the expected folded result.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      pend.delete();
      expq.delete();
    end else if (flush) begin
      pend.delete();
    end else if (in_valid && in_ready) begin
      if (in_ins[38:33] >= 6'd61) begin
        pend.push_back('{pc: in_pc, lvl: int'(in_ins[34:33]), pay: in_ins[32:6]});
      end else begin
        expq.push_back(build(in_pc, in_ins));
        pend.delete();
      end
    end
  end

  // Monitor: compares each consumed output and checks stability under back-pressure.
  bit        stall_prev = 0;
  con_fold_t snap;
  always begin
    con_fold_t e;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (stall_prev) begin
        chk("hold_pc", 80'(out_pc), 80'(snap.pc));
        chk("hold_ins", 80'(out_ins), 80'(snap.ins));
        chk("hold_imm", out_imm, snap.imm);
        chk("hold_valid", 80'(out_valid), 80'd1);
      end
      if (flush) begin
        if (out_valid && expq.size() > 0) void'(expq.pop_front());
      end else if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out act=%h exp=none", out_ins);
        end else begin
          e = expq.pop_front();
          chk("pc", 80'(out_pc), 80'(e.pc));
          chk("ins", 80'(out_ins), 80'(e.ins));
          chk("imm", out_imm, e.imm);
          chk("len", 80'(out_len), 80'(e.len));
          chk("perr", 80'(out_perr), 80'(e.perr));
        end
      end
    end
    stall_prev = !rst && !flush && out_valid && !out_ready;
    snap = '{pc: out_pc, ins: out_ins, imm: out_imm, len: out_len, perr: out_perr};
  end

  task automatic put(input logic [39:0] pc, input logic [39:0] ins);
    @(negedge clk);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (in_ready && !flush && !rst) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL put_timeout act=no_accept exp=accept");
  endtask

  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  function automatic logic [39:0] gen_ins();
    if ($urandom % 3 == 0)
      return {1'($urandom), 6'(61 + $urandom % 3), 27'($urandom), 6'($urandom)};
    return {1'($urandom), 6'($urandom % 61), 15'($urandom), 18'($urandom)};
  endfunction

  initial begin
    bit hold;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_ins = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 80'(out_valid), 80'd0);
    chk("rst_pc", 80'(out_pc), 80'd0);
    chk("rst_ins", 80'(out_ins), 80'd0);
    chk("rst_imm", out_imm, 80'd0);
    chk("rst_len", 80'(out_len), 80'd1);
    chk("rst_perr", 80'(out_perr), 80'd0);
    @(negedge clk);
    rst = 1'b0;

    put(40'h100, mk_ri(ADDI, 15'h7FFF));
    settle();
    chk("lat_valid", 80'(out_valid), 80'd1);
    chk("d1_imm", out_imm, ~80'd0);
    chk("d1_len", 80'(out_len), 80'd1);

    put(40'h200, mk_con(1, 27'h1));
    put(40'h201, mk_ri(ADDI, 15'h5));
    settle();
    chk("d2_imm", out_imm, 80'h8005);
    chk("d2_len", 80'(out_len), 80'd2);
    chk("d2_pc", 80'(out_pc), 80'h200);

    put(40'h300, mk_con(1, 27'h7FFFFFF));
    put(40'h301, mk_con(2, 27'h0));
    put(40'h302, mk_con(3, 27'h7FF));
    put(40'h303, mk_ri(ORI, 15'h0));
    settle();
    chk("d3_imm", out_imm, {11'h7FF, 27'h0, 27'h7FFFFFF, 15'h0});
    chk("d3_len", 80'(out_len), 80'd4);
    chk("d3_perr", 80'(out_perr), 80'd0);

    put(40'h400, mk_con(2, 27'h3));
    put(40'h401, mk_con(1, 27'h4));
    put(40'h402, mk_ri(ADDI, 15'h0));
    settle();
    chk("d4_perr", 80'(out_perr), 80'd1);

    put(40'h410, mk_con(1, 27'h123));
    put(40'h411, mk_con(1, 27'h456));
    put(40'h412, mk_ri(ADDI, 15'h0));
    settle();
    chk("d5_perr", 80'(out_perr), 80'd1);
    chk("d5_imm", out_imm, {38'h0, 27'h456, 15'h0});

    @(negedge clk);
    out_ready = 1'b0;
    put(40'h500, mk_ri(ADDI, 15'h11));
    @(negedge clk);
    in_pc  = 40'h501;
    in_ins = mk_ri(ADDI, 15'h22);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 80'(in_ready), 80'd0);
      chk("stall_ins", 80'(out_ins), 80'(mk_ri(ADDI, 15'h11)));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 80'(in_ready), 80'd1);
    put(40'h502, mk_ri(ADDI, 15'h33));
    chk("b2b_1", 80'(out_ins), 80'(mk_ri(ADDI, 15'h22)));
    settle();
    chk("b2b_2", 80'(out_ins), 80'(mk_ri(ADDI, 15'h33)));
    chk("b2b_valid", 80'(out_valid), 80'd1);

    put(40'h600, mk_con(1, 27'h55));
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    put(40'h601, mk_ri(ADDI, 15'h1));
    settle();
    chk("fl_imm", out_imm, 80'd1);
    chk("fl_len", 80'(out_len), 80'd1);
    chk("fl_pc", 80'(out_pc), 80'h601);

    put(40'h700, mk_con(1, 27'h55));
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    put(40'h701, mk_ri(ADDI, 15'h1));
    settle();
    chk("rs_imm", out_imm, 80'd1);
    chk("rs_len", 80'(out_len), 80'd1);
    chk("rs_pc", 80'(out_pc), 80'h701);

    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = ($urandom % 5) != 0;
        in_pc    = {8'($urandom), $urandom};
        in_ins   = gen_ins();
      end
      flush     = ($urandom % 40) == 0;
      rst       = ($urandom % 400) == 0;
      out_ready = ($urandom % 4) != 0;
      #1;
      hold = in_valid && !(in_ready && !flush && !rst);
    end

    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("drain", 80'(expq.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
